// File: rtl/tbird_turn_ctrl.sv
`default_nettype none
// ============================================================================
// tbird_turn_ctrl - switch conditioning, step prescaler and sweep-aligned
// mode sequencing for the tail-light sequencers.   Revision: 1.0
// ============================================================================

module tbird_turn_ctrl_cond #(
  parameter int DEB = 500_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level
);
  localparam int            CW       = (DEB > 1) ? $clog2(DEB) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB - 1);

  logic          sync_a;
  logic          sync_b;
  logic [CW-1:0] cnt;

  // The count only advances while the synchronized value disagrees with the
  // accepted level; any agreement (a bounce back) restarts it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      level  <= 1'b0;
      cnt    <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      if (sync_b == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_b;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

module tbird_turn_ctrl_presc #(
  parameter int DIV = 12_500_000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);
  localparam int            PW       = $clog2(DIV);
  localparam logic [PW-1:0] CNT_LAST = PW'(DIV - 1);

  logic [PW-1:0] cnt;

  assign tick = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PW'(1);
    end
  end
endmodule

module tbird_turn_ctrl #(
  parameter int DIV     = 12_500_000,
  parameter int DEB     = 500_000,
  parameter int SEQ_LEN = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       turn_left_raw,
  input  logic                       turn_right_raw,
  input  logic                       hazard_raw,
  output logic                       step,
  output logic                       left_en,
  output logic                       right_en,
  output logic [1:0]                 mode,
  output logic [$clog2(SEQ_LEN)-1:0] phase
);
  localparam int            SW      = $clog2(SEQ_LEN);
  localparam logic [SW-1:0] PH_LAST = SW'(SEQ_LEN - 1);

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'd0,
    MODE_LEFT   = 2'd1,
    MODE_RIGHT  = 2'd2,
    MODE_HAZARD = 2'd3
  } mode_t;

  logic [2:0]    raw_vec;
  logic [2:0]    lvl;
  logic          tick;
  mode_t         req;
  mode_t         mode_q;
  mode_t         mode_d;
  logic [SW-1:0] phase_q;
  logic [SW-1:0] phase_d;
  logic          step_q;
  logic          step_d;

  assign raw_vec = {hazard_raw, turn_right_raw, turn_left_raw};

  for (genvar gi = 0; gi < 3; gi++) begin : g_cond
    tbird_turn_ctrl_cond #(
      .DEB(DEB)
    ) u_cond (
      .clk    (clk),
      .reset_n(reset_n),
      .raw    (raw_vec[gi]),
      .level  (lvl[gi])
    );
  end

  tbird_turn_ctrl_presc #(
    .DIV(DIV)
  ) u_presc (
    .clk    (clk),
    .reset_n(reset_n),
    .tick   (tick)
  );

  always_comb begin
    req = MODE_IDLE;
    if (lvl[2] || (lvl[0] && lvl[1])) begin
      req = MODE_HAZARD;
    end else if (lvl[0]) begin
      req = MODE_LEFT;
    end else if (lvl[1]) begin
      req = MODE_RIGHT;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q  <= MODE_IDLE;
      phase_q <= '0;
      step_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      phase_q <= phase_d;
      step_q  <= step_d;
    end
  end

  // A new request is only taken from IDLE or on the tick that closes a sweep,
  // so the downstream lamp pattern always completes.
  always_comb begin
    mode_d  = mode_q;
    phase_d = phase_q;
    step_d  = tick && (mode_q != MODE_IDLE);
    if (tick) begin
      if (mode_q == MODE_IDLE) begin
        mode_d = req;
      end else if (phase_q == PH_LAST) begin
        phase_d = '0;
        mode_d  = req;
      end else begin
        phase_d = phase_q + SW'(1);
      end
    end
  end

  assign step     = step_q;
  assign mode     = mode_q;
  assign phase    = phase_q;
  assign left_en  = (mode_q == MODE_LEFT)  || (mode_q == MODE_HAZARD);
  assign right_en = (mode_q == MODE_RIGHT) || (mode_q == MODE_HAZARD);

endmodule

`default_nettype wire

// File: tb/tb_tbird_turn_ctrl.sv
`default_nettype none
// ============================================================================
// tb_tbird_turn_ctrl - table, directed and random checks against a
// behavioural model of tbird_turn_ctrl.   Revision: 1.0
// ============================================================================
module tb_tbird_turn_ctrl;
  localparam int DIV     = 4;
  localparam int DEB     = 3;
  localparam int SEQ_LEN = 4;
  localparam int PW      = $clog2(SEQ_LEN);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          l = 1'b0;
  logic          r = 1'b0;
  logic          h = 1'b0;
  logic          step;
  logic          left_en;
  logic          right_en;
  logic [1:0]    mode;
  logic [PW-1:0] phase;

  tbird_turn_ctrl #(
    .DIV    (DIV),
    .DEB    (DEB),
    .SEQ_LEN(SEQ_LEN)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .turn_left_raw (l),
    .turn_right_raw(r),
    .hazard_raw    (h),
    .step          (step),
    .left_en       (left_en),
    .right_en      (right_en),
    .mode          (mode),
    .phase         (phase)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: edges since reset, a raw-sample delay line, and a window
  // of the most recent DEB synchronized samples per switch.
  int         m_mode, m_phase, m_step, m_edges;
  logic [2:0] m_filt;
  logic [2:0] raw_hist[$];
  logic [2:0] hist[$];

  function automatic int req_of(input logic [2:0] f);
    if (f[2] || (f[0] && f[1])) return 3;
    if (f[0]) return 1;
    if (f[1]) return 2;
    return 0;
  endfunction

  function void model_reset();
    m_mode = 0; m_phase = 0; m_step = 0; m_edges = 0; m_filt = 3'b000;
    raw_hist.delete(); raw_hist.push_back(3'b000); raw_hist.push_back(3'b000);
    hist.delete();
  endfunction

  function void model_edge();
    logic [2:0] s;
    int req;
    bit tk, all_diff;
    s = raw_hist.pop_front();
    raw_hist.push_back({h, r, l});
    req = req_of(m_filt);
    m_edges++;
    tk = (m_edges % DIV) == 0;
    m_step = (tk && m_mode != 0) ? 1 : 0;
    if (tk) begin
      if (m_mode == 0) m_mode = req;
      else begin
        m_phase = (m_phase + 1) % SEQ_LEN;
        if (m_phase == 0) m_mode = req;
      end
    end
    hist.push_back(s);
    if (hist.size() > DEB) void'(hist.pop_front());
    if (hist.size() == DEB) begin
      for (int i = 0; i < 3; i++) begin
        all_diff = 1;
        foreach (hist[k]) if (hist[k][i] == m_filt[i]) all_diff = 0;
        if (all_diff) m_filt[i] = ~m_filt[i];
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at time %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("step",     32'(step),     32'(m_step));
    chk("mode",     32'(mode),     32'(m_mode));
    chk("phase",    32'(phase),    32'(m_phase));
    chk("left_en",  32'(left_en),  32'((m_mode == 1 || m_mode == 3) ? 1 : 0));
    chk("right_en", 32'(right_en), 32'((m_mode == 2 || m_mode == 3) ? 1 : 0));
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (reset_n) model_edge();
      #1;
      chk_model();
    end
  endtask

  typedef struct {
    logic       l, r, h;
    logic [1:0] m;
    logic       le, re;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  first_step, nsteps, prev_phase, v;
    bit  done;

    tbl[0] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 2'd3, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 1'b1};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};

    // Reset held with every switch on, then first step timing and hazard.
    model_reset();
    l = 1; r = 1; h = 1;
    cyc(10);
    reset_n = 1'b1;
    first_step = 0;
    for (int k = 1; k <= 30; k++) begin
      cyc(1);
      if (step && first_step == 0) first_step = k;
    end
    chk("first_step_edge", 32'(first_step), 32'd12);
    chk("hazard_mode", 32'(mode), 32'd3);
    chk("hazard_en", 32'({left_en, right_en}), 32'd3);

    // Releasing hazard: IDLE appears only as phase wraps from the last step.
    l = 0; r = 0; h = 0;
    done = 0; prev_phase = int'(phase);
    for (int k = 0; k < 60 && !done; k++) begin
      cyc(1);
      if (mode == 2'd0) begin
        chk("idle_prev_phase", 32'(prev_phase), 32'(SEQ_LEN - 1));
        chk("idle_phase", 32'(phase), 32'd0);
        done = 1;
      end
      prev_phase = int'(phase);
    end
    if (!done) chk("idle_timeout", 32'd0, 32'd1);

    // Left sweep: one step every DIV cycles.
    l = 1;
    cyc(12);
    nsteps = 0;
    for (int k = 0; k < 5 * DIV; k++) begin
      cyc(1);
      if (step) nsteps++;
    end
    chk("left_steps", 32'(nsteps), 32'd5);
    chk("left_mode", 32'(mode), 32'd1);
    chk("left_en_pair", 32'({left_en, right_en}), 32'd2);

    // Boundary hold: switch to right at phase 1.
    done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      cyc(1);
      if (m_mode == 1 && m_phase == 1) done = 1;
    end
    if (!done) chk("reach_phase1_timeout", 32'd0, 32'd1);
    l = 0; r = 1;
    done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      cyc(1);
      if (phase == '0) begin
        chk("boundary_new_mode", 32'(mode), 32'd2);
        done = 1;
      end else begin
        chk("boundary_hold", 32'(mode), 32'd1);
      end
    end
    if (!done) chk("boundary_timeout", 32'd0, 32'd1);

    // Back to IDLE, then bouncing right switch must be ignored.
    r = 0;
    done = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      cyc(1);
      if (mode == 2'd0) done = 1;
    end
    if (!done) chk("idle_return_timeout", 32'd0, 32'd1);
    cyc(4);
    for (int k = 0; k < 20; k++) begin
      if (k % 2 == 0) r = ~r;
      cyc(1);
      chk("bounce_mode", 32'(mode), 32'd0);
      chk("bounce_step", 32'(step), 32'd0);
    end
    r = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      chk("bounce_mode_after", 32'(mode), 32'd0);
      chk("bounce_step_after", 32'(step), 32'd0);
    end

    // Table vectors: settled mode for each switch combination.
    for (int i = 0; i < 9; i++) begin
      l = tbl[i].l; r = tbl[i].r; h = tbl[i].h;
      cyc(26);
      chk("tbl_mode", 32'(mode), 32'(tbl[i].m));
      chk("tbl_left_en", 32'(left_en), 32'(tbl[i].le));
      chk("tbl_right_en", 32'(right_en), 32'(tbl[i].re));
    end

    // Random switch activity, including short bounces.
    for (int s = 0; s < 60; s++) begin
      v = int'($urandom_range(0, 7));
      l = v[0]; r = v[1]; h = v[2];
      cyc(int'($urandom_range(1, 30)));
    end

    // Asynchronous reset at phase 2 of a left sweep.
    l = 1; r = 0; h = 0;
    done = 0;
    for (int k = 0; k < 80 && !done; k++) begin
      cyc(1);
      if (m_mode == 1 && m_phase == 2) done = 1;
    end
    if (!done) chk("reach_phase2_timeout", 32'd0, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_step", 32'(step), 32'd0);
    chk("async_mode", 32'(mode), 32'd0);
    chk("async_phase", 32'(phase), 32'd0);
    chk("async_en", 32'({left_en, right_en}), 32'd0);
    model_reset();
    cyc(2);
    reset_n = 1'b1;
    cyc(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/tbird_turn_ctrl.md
# tbird_turn_ctrl

Upstream control stage for the tail-light sequencers. It conditions the raw turn/hazard switches and divides the 50 MHz board clock into a slow step strobe. It then decides, once per step, which side's sequencer runs. Outputs drive the per-side `in` request and a step clock-enable of the downstream three-lamp sequencers. Mode changes are held back to sequence boundaries, so a lamp pattern is never cut mid-sweep.

## Interface
- `DIV`, 12_500_000: clk cycles per step tick (4 Hz at 50 MHz); ≥2.
- `DEB`, 500_000: consecutive stable cycles required to accept a switch change (10 ms); ≥1.
- `SEQ_LEN`, 4: steps in one downstream sweep (off→c→bc→abc→off); ≥2.

- `clk` in 1: board clock (CLOCK_50).
- `reset_n` in 1: asynchronous, active-low reset.
- `turn_left_raw` in 1: left switch, active-high level, asynchronous.
- `turn_right_raw` in 1: right switch, active-high level, asynchronous.
- `hazard_raw` in 1: hazard switch, active-high level, asynchronous.
- `step` out 1: one-cycle pulse; downstream sequencers advance on it.
- `left_en` out 1: request to left sequencer.
- `right_en` out 1: request to right sequencer.
- `mode` out 2: 0 IDLE, 1 LEFT, 2 RIGHT, 3 HAZARD.
- `phase` out ceil(log2(SEQ_LEN)): position in current sweep.

## Operation
- Input conditioning is the same for each raw input.
  - A 2-FF synchronizer feeds a debounce counter.
  - The filtered level takes the synchronized value only after the value differs from the filtered level for DEB consecutive cycles.
  - Any bounce back restarts the count.
- Requested mode is combinational from the filtered levels, in priority order:
  - hazard, or left and right together → HAZARD
  - left → LEFT
  - right → RIGHT
  - none → IDLE
- Prescaler: counter 0..DIV-1. `tick` is asserted when count == DIV-1, and the counter then wraps to 0. The prescaler runs freely in every mode.
- Mode/phase FSM, evaluated on `tick` only:
  - When mode == IDLE: mode ← requested mode; phase stays 0; no `step`.
  - When mode ≠ IDLE: phase ← (phase+1) mod SEQ_LEN. If phase == SEQ_LEN-1 (wrap), mode ← requested mode (may be IDLE); otherwise mode is held.
- `step` = tick & (mode ≠ IDLE), computed from the registered mode before update. It is registered, so it appears one cycle after tick.
- `left_en` = mode ∈ {LEFT, HAZARD}; `right_en` = mode ∈ {RIGHT, HAZARD}. Both are decoded directly from the mode register.
- A request that changes mid-sweep is not acted on until the wrap tick. A request that returns to the current mode before the wrap is invisible.
- Reset mid-operation asynchronously clears all state. Downstream must be reset by the same `reset_n`.

## Timing
- Reset values:
  - `step`=0, `left_en`=0, `right_en`=0, `mode`=0, `phase`=0
  - prescaler=0; synchronizers, filtered levels and debounce counters = 0.
- Latency from raw edge to requested-mode change: 2 + DEB cycles, provided the input is stable.
- Latency from requested-mode change to `mode` update:
  - from IDLE, the next tick;
  - otherwise, the next tick on which phase == SEQ_LEN-1.
- `step` is high for exactly 1 cycle, at most once per DIV cycles. It is never asserted while mode == IDLE.
- `left_en`/`right_en` change only in the cycle after a tick, together with `mode`.
- First `step` after leaving IDLE comes one full DIV period after the mode update.

## Test plan
Unless stated, all scenarios use DIV=4, DEB=3, SEQ_LEN=4.
- Reset:
  - Stimulus: hold `reset_n`=0 for 10 cycles with all raw inputs at 1.
  - Required response: all outputs 0; no `step`; first `step` no earlier than 2+3+4 cycles after release.
- Left sweep:
  - Stimulus: `turn_left_raw`=1 held.
  - Required response: `mode`=1, `left_en`=1, `right_en`=0; `step` every 4 cycles; `phase` sequence 0,1,2,3,0.
- Debounce:
  - Stimulus: toggle `turn_right_raw` 1/0 every 2 cycles for 20 cycles, then leave it at 0.
  - Required response: `mode` stays 0; no `step`.
- Boundary hold:
  - Stimulus: in LEFT at phase 1, switch to right only.
  - Required response: `mode` stays 1 through phase 2 and 3; it becomes 2 on the wrap tick, with `phase`=0.
- Hazard priority:
  - Stimulus: left, right and hazard all 1 from IDLE.
  - Required response: `mode`=3; `left_en`=`right_en`=1.
  - Stimulus: release all three.
  - Required response: IDLE only after `phase` wraps from 3.
- Async reset mid-sweep:
  - Stimulus: pulse `reset_n` low at phase 2.
  - Required response: outputs 0 in the same cycle, without waiting for a clock edge.
